// File: rtl/pll_reset_gen_pkg.sv
// Shared types and helpers for the PLL lock qualifier / reset generator.
package pll_reset_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_LOCK, STABILISE, HOLD, RUN} pll_rst_state_t;

  // Width that holds max(a,b) exactly, so the terminal compare never needs a wrap.
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/pll_reset_gen_sync_2ff.sv
// Width-parameterised two-flop synchroniser with synchronous reset to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             sreset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (sreset) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_gen.sv
// Qualifies raw PLL LOCK and sequences the downstream reset (rst_out) for the PLL clock domain.
// Optional lock-loss counter output is built only when PLL_LOSS_COUNT_EN is defined.
module pll_reset_gen
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 16
`ifdef PLL_LOSS_COUNT_EN
  , parameter int LOSS_CNT_W       = 8
`endif
) (
  input  logic clk,
  input  logic sreset,
  input  logic pll_lock,
  output logic rst_out,
`ifdef PLL_LOSS_COUNT_EN
  output logic locked,
  output logic [LOSS_CNT_W-1:0] loss_count
`else
  output logic locked
`endif
);

  localparam int            CW         = cnt_width(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE_CYCLES);
  localparam logic [CW-1:0] HOLD_MAX   = CW'(RESET_HOLD_CYCLES);

  pll_rst_state_t state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           lock_s;
  logic           run_nxt;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk    (clk),
    .sreset (sreset),
    .din    (pll_lock),
    .dout   (lock_s)
  );

  // Outputs are registered from the next state so a lock drop in RUN is seen on the very next edge.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state   <= IDLE;
      cnt     <= '0;
      rst_out <= 1'b1;
      locked  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rst_out <= ~run_nxt;
      locked  <= run_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        state_nxt = WAIT_LOCK;
        cnt_nxt   = '0;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABILISE;
          cnt_nxt   = CW'(1);
        end
      end
      STABILISE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_MAX) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_MAX) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef PLL_LOSS_COUNT_EN
  logic loss_evt;

  always_comb begin
    run_nxt  = (state_nxt == RUN);
    loss_evt = (state == RUN) && !lock_s;
  end

  // Saturating: a flapping PLL must not wrap the count back to a healthy-looking value.
  always_ff @(posedge clk) begin
    if (sreset) begin
      loss_count <= '0;
    end else if (loss_evt && (loss_count != '1)) begin
      loss_count <= loss_count + LOSS_CNT_W'(1);
    end
  end
`else
  always_comb begin
    run_nxt = (state_nxt == RUN);
  end
`endif

endmodule

// File: tb/tb_pll_reset_gen.sv
// Self-checking bench for pll_reset_gen: three parameterisations share one stimulus stream.
// Build with PLL_LOSS_COUNT_EN defined to also cover the lock-loss counter.
module tb_pll_reset_gen;

  logic clk = 1'b0;
  logic sreset;
  logic pll_lock;
  logic rst0, lk0, rst1, lk1, rst2, lk2;
`ifdef PLL_LOSS_COUNT_EN
  logic [7:0] lc0;
  logic [1:0] lc1;
  logic [7:0] lc2;
`endif

  int total = 0;
  int bad   = 0;
  bit monitor_en = 1'b0;

  always #5 clk = ~clk;

  pll_reset_gen #(.LOCK_STABLE_CYCLES(1024), .RESET_HOLD_CYCLES(16)
`ifdef PLL_LOSS_COUNT_EN
    , .LOSS_CNT_W(8)
`endif
  ) dut0 (.clk(clk), .sreset(sreset), .pll_lock(pll_lock), .rst_out(rst0), .locked(lk0)
`ifdef PLL_LOSS_COUNT_EN
    , .loss_count(lc0)
`endif
  );

  pll_reset_gen #(.LOCK_STABLE_CYCLES(5), .RESET_HOLD_CYCLES(3)
`ifdef PLL_LOSS_COUNT_EN
    , .LOSS_CNT_W(2)
`endif
  ) dut1 (.clk(clk), .sreset(sreset), .pll_lock(pll_lock), .rst_out(rst1), .locked(lk1)
`ifdef PLL_LOSS_COUNT_EN
    , .loss_count(lc1)
`endif
  );

  pll_reset_gen #(.LOCK_STABLE_CYCLES(1), .RESET_HOLD_CYCLES(1)
`ifdef PLL_LOSS_COUNT_EN
    , .LOSS_CNT_W(8)
`endif
  ) dut2 (.clk(clk), .sreset(sreset), .pll_lock(pll_lock), .rst_out(rst2), .locked(lk2)
`ifdef PLL_LOSS_COUNT_EN
    , .loss_count(lc2)
`endif
  );

  // Reference: RUN means lock_s was seen high on the last STABLE+HOLD+1 eligible edges.
  int thr[3]      = '{1041, 9, 3};
  int loss_max[3] = '{255, 3, 255};
  int streak[3]   = '{0, 0, 0};
  int loss_m[3]   = '{0, 0, 0};
  bit idle_m = 1'b1;
  bit d1 = 1'b0;
  bit d2 = 1'b0;

  always @(posedge clk) begin
    bit ls;
    ls = d2;
    if (sreset) begin
      d1 = 1'b0;
      d2 = 1'b0;
      idle_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
        streak[i] = 0;
        loss_m[i] = 0;
      end
    end else begin
      d2 = d1;
      d1 = pll_lock;
      for (int i = 0; i < 3; i++) begin
        if (idle_m) begin
          streak[i] = 0;
        end else if (ls) begin
          streak[i] = (streak[i] + 1 > thr[i]) ? thr[i] : streak[i] + 1;
        end else begin
          if (streak[i] >= thr[i] && loss_m[i] < loss_max[i]) loss_m[i]++;
          streak[i] = 0;
        end
      end
      idle_m = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit sr, input bit lk, input int n);
    sreset   = sr;
    pll_lock = lk;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (monitor_en) begin
      checkOutput("mon_rst0", rst0, (streak[0] < thr[0]) ? 1 : 0);
      checkOutput("mon_lk0",  lk0,  (streak[0] < thr[0]) ? 0 : 1);
      checkOutput("mon_rst1", rst1, (streak[1] < thr[1]) ? 1 : 0);
      checkOutput("mon_lk1",  lk1,  (streak[1] < thr[1]) ? 0 : 1);
      checkOutput("mon_rst2", rst2, (streak[2] < thr[2]) ? 1 : 0);
      checkOutput("mon_lk2",  lk2,  (streak[2] < thr[2]) ? 0 : 1);
`ifdef PLL_LOSS_COUNT_EN
      checkOutput("mon_lc0", lc0, loss_m[0]);
      checkOutput("mon_lc1", lc1, loss_m[1]);
      checkOutput("mon_lc2", lc2, loss_m[2]);
`endif
    end
  end

  typedef struct {
    bit sr;
    bit lk;
    int n;
    bit exp_rst;
  } vec_t;

  vec_t tbl[14];

  initial begin
    // Vectors target dut1 (STABLE=5, HOLD=3); state carries over from row to row.
    tbl[0]  = '{1'b1, 1'b0, 3,  1'b1};
    tbl[1]  = '{1'b0, 1'b1, 10, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1,  1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5,  1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1,  1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8,  1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1,  1'b0};
    tbl[9]  = '{1'b0, 1'b0, 3,  1'b1};
    tbl[10] = '{1'b0, 1'b1, 8,  1'b1};
    tbl[11] = '{1'b1, 1'b1, 1,  1'b1};
    tbl[12] = '{1'b0, 1'b1, 10, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 1,  1'b0};

    sreset   = 1'b1;
    pll_lock = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 14; v++) begin
      applyStimulus(tbl[v].sr, tbl[v].lk, tbl[v].n);
      checkOutput($sformatf("tbl%0d_rst", v), rst1, tbl[v].exp_rst);
      checkOutput($sformatf("tbl%0d_locked", v), lk1, !tbl[v].exp_rst);
      if (v == 0) monitor_en = 1'b1;
    end

    // Full-size release from reset; the 1/1 instance releases on the third lock_s edge.
    applyStimulus(1'b1, 1'b0, 2);
    checkOutput("reset_rst0", rst0, 1);
    checkOutput("reset_lk0", lk0, 0);
    applyStimulus(1'b0, 1'b1, 4);
    checkOutput("corner_rst2_before", rst2, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("corner_rst2_after", rst2, 0);
    applyStimulus(1'b0, 1'b1, 1037);
    checkOutput("full_rst0_before", rst0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("full_rst0_after", rst0, 0);
    checkOutput("full_lk0_after", lk0, 1);

    // One-cycle lock glitch in RUN: reset re-asserts after sync + output register.
    applyStimulus(1'b0, 1'b0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("glitch_rst0_edge2", rst0, 0);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("glitch_rst0_edge3", rst0, 1);
    checkOutput("glitch_lk0_edge3", lk0, 0);
`ifdef PLL_LOSS_COUNT_EN
    checkOutput("glitch_lc0", lc0, 1);
`endif
    applyStimulus(1'b0, 1'b1, 1040);
    checkOutput("relock_rst0_before", rst0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("relock_rst0_after", rst0, 0);

    // Lock drop during STABILISE restarts the whole window.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 500);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("drop_rst0", rst0, 1);
    applyStimulus(1'b0, 1'b1, 1042);
    checkOutput("drop_rst0_before", rst0, 1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("drop_rst0_after", rst0, 0);

    // sreset while dut0 sits in HOLD.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1030);
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("midhold_rst0", rst0, 1);
`ifdef PLL_LOSS_COUNT_EN
    checkOutput("midhold_lc0", lc0, 0);
`endif
    applyStimulus(1'b0, 1'b1, 1043);
    checkOutput("midhold_rst0_release", rst0, 0);

`ifdef PLL_LOSS_COUNT_EN
    applyStimulus(1'b1, 1'b0, 2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 12);
      applyStimulus(1'b0, 1'b0, 3);
    end
    checkOutput("loss_saturate_lc1", lc1, 3);
`endif

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 39) == 0) applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1);
      applyStimulus(1'b0, 1'b1, int'($urandom_range(1, 20)));
      applyStimulus(1'b0, 1'b0, int'($urandom_range(1, 4)));
    end

    @(posedge clk);
    #1;
    monitor_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
